// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU sharing arbiter.
// Holds FSM state encoding and the packed ALU control bundle.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } alu_arb_state_t;

    localparam int ALU_OP_W = 6;

    typedef struct packed {
        logic [2:0] sel;
        logic       addb;
        logic       rightb;
        logic       logicb;
    } alu_op_t;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin picker.
// Grants the first set request at or after ptr, scanning cyclically.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        int   j;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (en && !found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters.
// Round-robin grant, registered operands, registered result with response handshake.
module alu_share_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int XLEN    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*XLEN-1:0]    req_a,
    input  logic [NUM_REQ*XLEN-1:0]    req_b,
    input  logic [NUM_REQ*ALU_OP_W-1:0] req_op,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [XLEN-1:0]            rsp_data,
    output logic [XLEN-1:0]            alu_a,
    output logic [XLEN-1:0]            alu_b,
    output logic [2:0]                 alu_sel,
    output logic                       alu_addb,
    output logic                       alu_rightb,
    output logic                       alu_logicb,
    input  logic [XLEN-1:0]            alu_s,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);

    alu_arb_state_t       state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [XLEN-1:0]      a_q, a_d, b_q, b_d;
    alu_op_t              op_q, op_d;
    logic [XLEN-1:0]      rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;

    logic [XLEN-1:0]      a_arr  [NUM_REQ];
    logic [XLEN-1:0]      b_arr  [NUM_REQ];
    alu_op_t              op_arr [NUM_REQ];

    logic [NUM_REQ-1:0]   gnt;
    logic [IW-1:0]        gnt_idx;
    logic                 arb_en;
    logic                 any_gnt;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[i*XLEN +: XLEN];
        assign b_arr[i]  = req_b[i*XLEN +: XLEN];
        assign op_arr[i] = alu_op_t'(req_op[i*ALU_OP_W +: ALU_OP_W]);
    end

    // Granting is only possible from IDLE or on the response handshake.
    assign arb_en = (state_q == IDLE) ||
                    (state_q == RESP && rsp_ready[owner_q]);

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign any_gnt = |gnt;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        unique case (state_q)
            IDLE: ;
            EXEC: begin
                rsp_data_d  = alu_s;
                rsp_valid_d = NUM_REQ'(1) << owner_q;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (any_gnt) begin
            a_d      = a_arr[gnt_idx];
            b_d      = b_arr[gnt_idx];
            op_d     = op_arr[gnt_idx];
            owner_d  = gnt_idx;
            rr_ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            state_d  = EXEC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready  = gnt;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = op_q.sel;
    assign alu_addb   = op_q.addb;
    assign alu_rightb = op_q.rightb;
    assign alu_logicb = op_q.logicb;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed + random bench for alu_share_arbiter with an ALU model on alu_s.
// Scoreboard queue pushed on request handshake, popped on response handshake.
module tb_alu_share_arbiter;

    localparam int N = 4;
    localparam int X = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*X-1:0] req_a, req_b;
    logic [N*6-1:0] req_op;
    logic [X-1:0]   rsp_data, alu_a, alu_b, alu_s;
    logic [2:0]     alu_sel;
    logic           alu_addb, alu_rightb, alu_logicb, busy;

    logic [N-1:0]   v;
    logic [X-1:0]   ra [N];
    logic [X-1:0]   rb [N];
    logic [5:0]     rop [N];

    typedef struct {
        int         owner;
        logic [X-1:0] data;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         m_ptr = 0;
    int         nrsp = 0;
    int         ncnt [N];
    logic [N-1:0] gmask;
    bit         cont = 0;
    bit         rnd = 0;
    int         c;
    int         n0;

    always #5 clk = ~clk;

    function automatic logic [X-1:0] alu_f(logic [X-1:0] a, logic [X-1:0] b,
                                           logic [5:0] op);
        case (op[5:3])
            3'd0: return op[2] ? a - b : a + b;
            3'd1: return op[0] ? (a | b) : (a & b);
            3'd2: return a ^ b;
            3'd3: return op[1] ? (a >> b[4:0]) : (a << b[4:0]);
            3'd4: return {31'b0, $signed(a) < $signed(b)};
            default: return b;
        endcase
    endfunction

    assign alu_s = alu_f(alu_a, alu_b, {alu_sel, alu_addb, alu_rightb, alu_logicb});

    always_comb begin
        req_valid = v;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*X +: X] = ra[i];
            req_b[i*X +: X] = rb[i];
            req_op[i*6 +: 6] = rop[i];
        end
    end

    alu_share_arbiter #(.NUM_REQ(N), .XLEN(X)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_addb   (alu_addb),
        .alu_rightb (alu_rightb),
        .alu_logicb (alu_logicb),
        .alu_s      (alu_s),
        .busy       (busy)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(logic [N-1:0] vv, int p);
        for (int k = 0; k < N; k++)
            if (vv[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic new_op(int i);
        ra[i]  = $urandom;
        rb[i]  = $urandom;
        rop[i] = 6'($urandom);
    endtask

    task automatic monitor();
        int   g;
        exp_t e;
        gmask = '0;
        if (req_ready != '0) begin
            g = pick(v, m_ptr);
            chk("grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
            if (g >= 0) begin
                e.owner = g;
                e.data  = alu_f(ra[g], rb[g], rop[g]);
                sb.push_back(e);
                m_ptr = (g + 1) % N;
                gmask = N'(1) << g;
            end
        end
        if ((rsp_valid & rsp_ready) != '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_owner", 32'(rsp_valid), 32'd1 << e.owner);
                chk("rsp_data", rsp_data, e.data);
                ncnt[e.owner]++;
                nrsp++;
            end
        end
    endtask

    task automatic post();
        for (int i = 0; i < N; i++) begin
            if (gmask[i]) begin
                if (cont) new_op(i);
                else v[i] = 1'b0;
            end
            if (rnd) begin
                if (!v[i] && $urandom_range(0, 2) == 0) begin
                    new_op(i);
                    v[i] = 1'b1;
                end else if (v[i] && !gmask[i] && $urandom_range(0, 15) == 0) begin
                    v[i] = 1'b0;
                end
            end
        end
        if (rnd) rsp_ready = N'($urandom);
    endtask

    task automatic advance();
        monitor();
        @(posedge clk);
        #1;
        post();
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 100 && (sb.size() != 0 || busy || v != '0); k++) begin
            @(negedge clk);
            advance();
        end
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_sb", sb.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        v = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0; rb[i] = '0; rop[i] = '0; ncnt[i] = 0;
        end
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_ctl", {alu_b[0], alu_sel, alu_addb, alu_rightb, alu_logicb}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single request
        rsp_ready = 4'hF;
        ra[0] = 32'd5; rb[0] = 32'd3; rop[0] = 6'b000000;
        v = 4'b0001;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h1);
        chk("single_busy0", 32'(busy), 32'd0);
        advance();
        @(negedge clk);
        chk("single_busy1", 32'(busy), 32'd1);
        chk("single_nors", 32'(rsp_valid), 32'd0);
        chk("single_alu_a", alu_a, 32'd5);
        chk("single_alu_b", alu_b, 32'd3);
        advance();
        @(negedge clk);
        chk("single_rsp_v", 32'(rsp_valid), 32'h1);
        chk("single_rsp_d", rsp_data, 32'd8);
        chk("single_busy2", 32'(busy), 32'd1);
        advance();
        @(negedge clk);
        chk("single_idle", 32'(busy), 32'd0);
        advance();

        // all four continuously requesting
        for (int i = 0; i < N; i++) begin
            new_op(i);
            ncnt[i] = 0;
        end
        cont = 1;
        v = 4'hF;
        n0 = nrsp;
        for (c = 0; c < 200 && nrsp - n0 < 40; c++) begin
            @(negedge clk);
            advance();
        end
        chk("all4_count", nrsp - n0, 32'd40);
        chk("all4_cycles", c, 32'd81);
        for (int i = 0; i < N; i++) chk("all4_fair", ncnt[i], 32'd10);
        cont = 0;
        v = '0;
        drain();

        // backpressure, non-owner ready bits ignored
        rsp_ready = 4'b1011;
        ra[2] = 32'h1234_5678; rb[2] = 32'h10; rop[2] = 6'b011010;
        v = 4'b0100;
        @(negedge clk);
        chk("bp_grant", 32'(req_ready), 32'h4);
        advance();
        @(negedge clk);
        advance();
        ra[0] = 32'd7; rb[0] = 32'd9; rop[0] = 6'b000000;
        v[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rsp_v", 32'(rsp_valid), 32'h4);
            chk("bp_rsp_d", rsp_data, 32'h1234);
            chk("bp_noready", 32'(req_ready), 32'd0);
            chk("bp_alu_a", alu_a, 32'h1234_5678);
            chk("bp_alu_sel", 32'(alu_sel), 32'd3);
            advance();
        end
        rsp_ready = 4'hF;
        @(negedge clk);
        chk("bp_b2b_grant", 32'(req_ready), 32'h1);
        advance();
        drain();

        // wrap and skip
        ra[2] = 32'd1; rb[2] = 32'd2; rop[2] = 6'b010000;
        v = 4'b0100;
        drain();
        ra[0] = 32'hF0; rb[0] = 32'h0F; rop[0] = 6'b001001;
        ra[2] = 32'd10; rb[2] = 32'd4; rop[2] = 6'b000100;
        v = 4'b0101;
        @(negedge clk);
        chk("wrap_g0", 32'(req_ready), 32'h1);
        advance();
        @(negedge clk);
        advance();
        @(negedge clk);
        chk("wrap_g2", 32'(req_ready), 32'h4);
        advance();
        drain();
        v = 4'hF;
        @(negedge clk);
        chk("wrap_ptr3", 32'(req_ready), 32'h8);
        advance();
        v = '0;
        drain();

        // reset during EXEC
        ra[1] = 32'hFFFF_FFFF; rb[1] = 32'd1; rop[1] = 6'b000000;
        v = 4'b0010;
        @(negedge clk);
        advance();
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rsp_v", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_d", rsp_data, 32'd0);
        chk("arst_alu_a", alu_a, 32'd0);
        chk("arst_alu_b", alu_b, 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        sb.delete();
        m_ptr = 0;
        @(negedge clk);
        rst = 1'b0;
        advance();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
            advance();
        end

        // random traffic
        rnd = 1;
        n0 = nrsp;
        for (c = 0; c < 6000 && nrsp - n0 < 500; c++) begin
            @(negedge clk);
            advance();
        end
        chk("rand_count", nrsp - n0, 32'd500);
        rnd = 0;
        v = '0;
        rsp_ready = 4'hF;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
